// File: rtl/control_fsm.sv
// control_fsm: multi-cycle processor control state machine.
//
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH. It drives the
// memory, IR, PC and register-file strobes. It also latches a registered ALU
// operation code and enters terminal HALT/ERROR states.
//
// Parameters:
//   ALUOP_W  width of ALUOp; the 4-bit code is zero-extended (default 4)
//   MEM_TO   cycles to wait for mem_ready before ERROR, 1..255 (default 15)
//   CNT_W    width of the performance counters (default 16)
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   opCode     instruction opcode, sampled in DECODE
//   mem_ready  memory handshake complete
//   flush      abort the current instruction (DECODE/EXEC/MEM/WB only)
//   ALUOp      registered ALU operation code
//   state      current FSM state
//   memRead, memWrite, irWrite, pcWrite, regWrite  control strobes
//   halted     high while in HALT
//   err        high while in ERROR (memory timeout)
//   retired    retired instruction count (CONTROL_FSM_PERF_EN only, else 0)
//   cycles     busy cycle count (CONTROL_FSM_PERF_EN only, else 0)
//
// Build option: define CONTROL_FSM_PERF_EN to add the retired/cycles counters.
module control_fsm #(
  parameter int ALUOP_W = 4,
  parameter int MEM_TO  = 15,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         opCode,
  input  logic               mem_ready,
  input  logic               flush,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [2:0]         state,
  output logic               memRead,
  output logic               memWrite,
  output logic               irWrite,
  output logic               pcWrite,
  output logic               regWrite,
  output logic               halted,
  output logic               err,
  output logic [CNT_W-1:0]   retired,
  output logic [CNT_W-1:0]   cycles
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  logic [2:0] state_reg, state_next;
  logic [3:0] op_reg;
  logic [3:0] aluop_reg;
  logic [7:0] wait_reg, wait_next;
  logic       wait_hit;
  logic       flush_act;

  function automatic logic [3:0] map_aluop(input logic [3:0] op);
    logic [3:0] code;
    if (!op[3])                          code = op;
    else if (op == OP_LW || op == OP_SW) code = 4'b1010;
    else if (op == 4'b1010)              code = 4'b1000;
    else if (op == 4'b1011)              code = 4'b1001;
    else                                 code = 4'b1100;
    return code;
  endfunction

  // This cycle would be the MEM_TO-th consecutive cycle without mem_ready.
  assign wait_hit  = (int'(wait_reg) + 1) >= MEM_TO;
  // flush only has an effect in the instruction-body states.
  assign flush_act = flush && (state_reg == S_DECODE || state_reg == S_EXEC ||
                               state_reg == S_MEM    || state_reg == S_WB);

  // State register, opcode/ALUOp latch and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_FETCH;
      op_reg    <= 4'd0;
      aluop_reg <= 4'd0;
      wait_reg  <= 8'd0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      if (state_reg == S_DECODE) begin
        op_reg    <= opCode;
        aluop_reg <= map_aluop(opCode);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH: begin
        if (mem_ready)     state_next = S_DECODE;
        else if (wait_hit) state_next = S_ERROR;
      end
      S_DECODE: state_next = flush ? S_FETCH : S_EXEC;
      S_EXEC: begin
        if (flush) state_next = S_FETCH;
        else begin
          case (op_reg)
            OP_LW, OP_SW: state_next = S_MEM;
            OP_B, OP_BR:  state_next = S_FETCH;
            OP_HLT:       state_next = S_HALT;
            default:      state_next = S_WB;
          endcase
        end
      end
      S_MEM: begin
        if (flush)          state_next = S_FETCH;
        else if (mem_ready) state_next = (op_reg == OP_SW) ? S_FETCH : S_WB;
        else if (wait_hit)  state_next = S_ERROR;
      end
      S_WB:    state_next = S_FETCH;
      S_HALT:  state_next = S_HALT;
      S_ERROR: state_next = S_ERROR;
      default: state_next = S_FETCH;
    endcase
  end

  // The counter runs only while waiting in FETCH/MEM; any state change clears it.
  assign wait_next = ((state_reg == S_FETCH || state_reg == S_MEM) &&
                      state_next == state_reg) ? wait_reg + 8'd1 : 8'd0;

  // Output logic. Strobes are gated by rst_n so they drop as soon as reset
  // asserts, not at the next clock edge.
  always_comb begin
    memRead  = 1'b0;
    memWrite = 1'b0;
    irWrite  = 1'b0;
    pcWrite  = 1'b0;
    regWrite = 1'b0;
    if (rst_n && !flush_act) begin
      case (state_reg)
        S_FETCH: begin
          memRead = 1'b1;
          irWrite = mem_ready;
          pcWrite = mem_ready;
        end
        S_EXEC:  pcWrite  = (op_reg == OP_B) || (op_reg == OP_BR);
        S_MEM: begin
          memRead  = (op_reg == OP_LW);
          memWrite = (op_reg == OP_SW);
        end
        S_WB:    regWrite = 1'b1;
        default: ;
      endcase
    end
  end

  assign state  = state_reg;
  assign ALUOp  = ALUOP_W'(aluop_reg);
  assign halted = (state_reg == S_HALT);
  assign err    = (state_reg == S_ERROR);

`ifdef CONTROL_FSM_PERF_EN
  logic [CNT_W-1:0] retired_reg, cycles_reg;
  logic             retire_evt;

  // Flushed or timed-out instructions do not retire.
  assign retire_evt = !flush_act &&
                      ((state_next == S_FETCH &&
                        (state_reg == S_WB || state_reg == S_EXEC || state_reg == S_MEM)) ||
                       (state_reg == S_EXEC && state_next == S_HALT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_reg <= '0;
      cycles_reg  <= '0;
    end else begin
      if (retire_evt) retired_reg <= retired_reg + 1'b1;
      if (state_reg != S_HALT && state_reg != S_ERROR) cycles_reg <= cycles_reg + 1'b1;
    end
  end

  assign retired = retired_reg;
  assign cycles  = cycles_reg;
`else
  assign retired = '0;
  assign cycles  = '0;
`endif

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameter ALUOP_W, default 4, ALUOp output width; values above 4 zero-extend the 4-bit code.
REQ-002 Parameter MEM_TO, default 15, max wait cycles for mem_ready before error; legal range 1..255.
REQ-003 Parameter CNT_W, default 16, width of the performance counters.
REQ-004 Ports, in order:
- clk  in  1  the single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- opCode  in  4  instruction opcode, sampled in DECODE.
- mem_ready  in  1  memory handshake complete.
- flush  in  1  abort current instruction.
- ALUOp  out  ALUOP_W  registered ALU operation code.
- state  out  3  current FSM state.
- memRead  out  1  memory read request (fetch or LW).
- memWrite  out  1  memory write request (SW).
- irWrite  out  1  instruction register load strobe.
- pcWrite  out  1  PC update strobe.
- regWrite  out  1  register file write strobe.
- halted  out  1  sticky HLT indicator.
- err  out  1  sticky memory-timeout indicator.
- retired  out  CNT_W  retired instruction count (macro only).
- cycles  out  CNT_W  busy cycle count (macro only).

Function
REQ-005 States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERROR=6; 7 is unreachable and SHALL recover to FETCH.
REQ-006 ALUOp mapping, latched in DECODE and held until the next DECODE:
- opcodes 0000..0111 map to the same code.
- 1000 (LW) and 1001 (SW) map to 1010.
- 1010 (LLB) maps to 1000; 1011 (LHB) maps to 1001.
- all other opcodes map to 1100.
REQ-007 FETCH: memRead=1; on mem_ready, irWrite=1 and pcWrite=1 in that same cycle (Mealy), then DECODE.
REQ-008 DECODE lasts 1 cycle, then EXEC.
REQ-009 EXEC lasts 1 cycle; next state by opcode:
- LW, SW: MEM.
- 0000..0111, LLB, LHB, 1110 (PCS): WB.
- 1100 (B), 1101 (BR): FETCH, with pcWrite=1 in EXEC.
- 1111 (HLT): HALT.
REQ-010 MEM: memRead=1 for LW, memWrite=1 for SW, held until mem_ready; then LW goes to WB and SW goes to FETCH.
REQ-011 WB: regWrite=1 for exactly 1 cycle, then FETCH.
REQ-012 Wait counter clears on entry to FETCH or MEM and increments each cycle without mem_ready; reaching MEM_TO enters ERROR; mem_ready in the same cycle wins.
REQ-013 HALT and ERROR are terminal until reset; all strobes 0; halted or err respectively = 1.
REQ-014 flush=1 in DECODE, EXEC, MEM or WB: next state FETCH; all strobes forced 0 that cycle.
REQ-015 flush is ignored in FETCH, HALT and ERROR.
REQ-016 Strobes in MEM, FETCH and WB derive from state only, except the Mealy strobes in REQ-007 and REQ-009.

Reset
REQ-017 rst_n low asynchronously forces: state=FETCH, ALUOp=0, all strobes 0, halted=0, err=0, wait counter=0, counters=0.
REQ-018 Reset asserted mid-instruction discards that instruction; no strobe is asserted after rst_n falls.

Configuration
REQ-019 Macro CONTROL_FSM_PERF_EN defined:
- retired increments on each transition into FETCH from WB, EXEC(B/BR) or MEM(SW), and on entry to HALT.
- cycles increments every cycle not in HALT or ERROR.
- both counters wrap modulo 2^CNT_W.
REQ-020 CONTROL_FSM_PERF_EN undefined: retired and cycles tied to 0; no counter flops.

Verification
REQ-021 ADD: opCode=0000, mem_ready=1 in FETCH -> states FETCH,DECODE,EXEC,WB; ALUOp=0000; regWrite high in WB only; back to FETCH on cycle 5.
REQ-022 LW: opCode=1000, mem_ready delayed 3 cycles in MEM -> ALUOp=1010; memRead held 4 cycles in MEM; then WB with regWrite=1.
REQ-023 Timeout: MEM_TO=15, mem_ready held 0 in FETCH -> ERROR after 15 cycles, err=1; ready on the 15th cycle instead -> DECODE.
REQ-024 Flush and undefined-opcode mapping:
- flush=1 in EXEC of SW -> next FETCH; memWrite never asserted.
- opCode=1100 -> ALUOp=1100 and pcWrite in EXEC.
REQ-025 HLT and reset: opCode=1111 -> HALT, halted=1; rst_n pulsed low mid-MEM -> outputs 0 immediately; with PERF_EN, retired=0 after reset.
